// File: rtl/vesp_pkg.sv
// Shared constants and enums for the VESP memory access controller.
package vesp_pkg;

    localparam int word_size    = 16;
    localparam int address_size = 12;

    typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

    // Requester IDs; the round-robin pointer holds the last winner of a contested cycle.
    typedef enum logic {LD = 1'b0, CPU = 1'b1} req_id_t;

endpackage

// File: rtl/vesp_rr_arb2.sv
// Two-way round-robin arbiter (loader vs processor) with a processor mask.
module vesp_rr_arb2
    import vesp_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_ld,
    input  logic i_req_cpu,
    input  logic i_mask_cpu,
    output logic o_gnt_ld,
    output logic o_gnt_cpu
);

    req_id_t r_ptr;
    logic    w_elig_ld;
    logic    w_elig_cpu;
    logic    w_both;

    assign w_elig_ld  = i_en & i_req_ld;
    assign w_elig_cpu = i_en & i_req_cpu & ~i_mask_cpu;
    assign w_both     = w_elig_ld & w_elig_cpu;

    // On contention the requester that did not win last time gets the port.
    assign o_gnt_ld  = w_elig_ld  & (~w_elig_cpu | (r_ptr == CPU));
    assign o_gnt_cpu = w_elig_cpu & (~w_elig_ld  | (r_ptr == LD));

    // Pointer only moves on contested cycles so uncontested traffic keeps the alternation phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= LD;
        end else if (w_both) begin
            r_ptr <= (r_ptr == LD) ? CPU : LD;
        end
    end

endmodule

// File: rtl/vesp_mem_ctrl.sv
// VESP main-memory port controller: hardware flush after reset/flush_req,
// then single-port sharing between loader and processor with 1-cycle read return.
module vesp_mem_ctrl
    import vesp_pkg::*;
#(
    parameter int flush_depth = 256
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [address_size-1:0] cpu_addr,
    input  logic [word_size-1:0]    cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [word_size-1:0]    cpu_rdata,
    input  logic                    ld_req,
    input  logic                    ld_we,
    input  logic [address_size-1:0] ld_addr,
    input  logic [word_size-1:0]    ld_wdata,
    output logic                    ld_gnt,
    output logic                    ld_rvalid,
    output logic [word_size-1:0]    ld_rdata,
    input  logic                    ld_hold,
    input  logic                    flush_req,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [address_size-1:0] mem_addr,
    output logic [word_size-1:0]    mem_wdata,
    input  logic [word_size-1:0]    mem_rdata,
    output logic                    flush_busy
);

    localparam int CW = $clog2(flush_depth) + 1;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_cpu_rvalid;
    logic                 r_ld_rvalid;
    logic [word_size-1:0] r_cpu_rdata;
    logic [word_size-1:0] r_ld_rdata;
    logic                 w_run;
    logic                 w_flushing;
    logic                 w_arb_en;
    logic                 w_cpu_gnt;
    logic                 w_ld_gnt;

    assign w_run      = (r_state == RUN);
    // Reset is folded in so the memory port is fully quiet while rst is low.
    assign w_flushing = (r_state == FLUSH) & rst;
    assign w_arb_en   = w_run & ~flush_req;

    vesp_rr_arb2 u_arb (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_en       (w_arb_en),
        .i_req_ld   (ld_req),
        .i_req_cpu  (cpu_req),
        .i_mask_cpu (ld_hold),
        .o_gnt_ld   (w_ld_gnt),
        .o_gnt_cpu  (w_cpu_gnt)
    );

    assign cpu_gnt    = w_cpu_gnt;
    assign ld_gnt     = w_ld_gnt;
    assign flush_busy = (r_state == FLUSH);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_flushing) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = address_size'(r_cnt);
        end else if (w_ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
        end else if (r_state == FLUSH) begin
            if (r_cnt == CW'(flush_depth - 1)) begin
                r_state <= RUN;
            end
            r_cnt <= r_cnt + CW'(1);
        end else if (flush_req) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
        end
    end

    // Read data is passed through in the rvalid cycle and captured so it holds afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpu_rvalid <= 1'b0;
            r_ld_rvalid  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ld_rdata   <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_ld_rvalid  <= w_ld_gnt & ~ld_we;
            if (r_cpu_rvalid) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (r_ld_rvalid) begin
                r_ld_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign ld_rvalid  = r_ld_rvalid;
    assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : r_cpu_rdata;
    assign ld_rdata   = r_ld_rvalid  ? mem_rdata : r_ld_rdata;

endmodule

// File: tb/tb_vesp_mem_ctrl.sv
// Bench for vesp_mem_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_vesp_mem_ctrl;
  import vesp_pkg::*;

  localparam int FD = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_wdata = '0;
  logic        ld_gnt, ld_rvalid;
  logic [15:0] ld_rdata;
  logic        ld_hold = 1'b0;
  logic        flush_req = 1'b0;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        flush_busy;

  always #5 clk = ~clk;

  vesp_mem_ctrl #(.flush_depth(FD)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ld_hold(ld_hold), .flush_req(flush_req),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .flush_busy(flush_busy)
  );

  // Memory array the controller drives (synchronous read)
  logic [15:0] mem_array [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:4095];
  int          flush_left;
  bit          last_cpu;
  logic [15:0] cpu_exp_q[$];
  logic [15:0] ld_exp_q[$];
  logic [15:0] cpu_last, ld_last;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    flush_left = FD;
    last_cpu   = 1'b0;
    cpu_exp_q.delete();
    ld_exp_q.delete();
    cpu_last = '0;
    ld_last  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, {30'b0, cpu_gnt, ld_gnt}, 32'h0);
    check_eq({tag, "_rvalid"}, {30'b0, cpu_rvalid, ld_rvalid}, 32'h0);
    check_eq({tag, "_rdata"}, {cpu_rdata, ld_rdata}, 32'h0);
    check_eq({tag, "_busy"}, {31'b0, flush_busy}, 32'h1);
    check_eq({tag, "_mem"}, {2'b0, mem_en, mem_we, mem_addr, mem_wdata}, 32'h0);
  endtask

  // One cycle: called just after a falling edge with inputs already applied.
  task automatic step();
    bit e_ld, e_cpu, g_ld, g_cpu, flushing, go_flush, rv_ld, rv_cpu;
    logic [31:0] obs_mem;
    logic [15:0] d;
    #1;
    flushing = (flush_left > 0);
    g_ld = 0; g_cpu = 0; go_flush = 0;
    check_eq("flush_busy", {31'b0, flush_busy}, {31'b0, flushing});
    if (!flushing) begin
      if (flush_req) go_flush = 1;
      else begin
        e_ld  = ld_req;
        e_cpu = cpu_req && !ld_hold;
        if (e_ld && e_cpu) begin
          g_cpu = !last_cpu;
          g_ld  = last_cpu;
          last_cpu = g_cpu;
        end else begin
          g_ld  = e_ld;
          g_cpu = e_cpu;
        end
      end
    end
    check_eq("ld_gnt", {31'b0, ld_gnt}, {31'b0, g_ld});
    check_eq("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, g_cpu});
    obs_mem = {2'b0, mem_en, mem_we, mem_addr, mem_wdata};
    if (flushing) check_eq("mem_flush", obs_mem, {2'b0, 1'b1, 1'b1, 12'(FD - flush_left), 16'h0});
    else if (g_ld) check_eq("mem_ld", obs_mem, {2'b0, 1'b1, ld_we, ld_addr, ld_wdata});
    else if (g_cpu) check_eq("mem_cpu", obs_mem, {2'b0, 1'b1, cpu_we, cpu_addr, cpu_wdata});
    else check_eq("mem_idle", {31'b0, mem_en}, 32'h0);
    rv_ld  = g_ld && !ld_we;
    rv_cpu = g_cpu && !cpu_we;
    if (flushing) begin
      ref_mem[FD - flush_left] = 16'h0;
      flush_left--;
    end else if (go_flush) flush_left = FD;
    if (g_ld) begin
      if (ld_we) ref_mem[ld_addr] = ld_wdata;
      else ld_exp_q.push_back(ref_mem[ld_addr]);
    end
    if (g_cpu) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else cpu_exp_q.push_back(ref_mem[cpu_addr]);
    end
    @(posedge clk);
    #1;
    check_eq("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, rv_ld});
    check_eq("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, rv_cpu});
    if (rv_ld) begin d = ld_exp_q.pop_front(); ld_last = d; end
    if (rv_cpu) begin d = cpu_exp_q.pop_front(); cpu_last = d; end
    check_eq("ld_rdata", {16'b0, ld_rdata}, {16'b0, ld_last});
    check_eq("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, cpu_last});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; ld_req = 0; ld_we = 0; ld_hold = 0; flush_req = 0;
  endtask

  task automatic ld_write(input logic [11:0] a, input logic [15:0] v);
    ld_req = 1; ld_we = 1; ld_addr = a; ld_wdata = v;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_array[i] = 16'($urandom);
      ref_mem[i]   = mem_array[i];
    end
    model_reset();
    idle_inputs();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1;
    model_reset();
    repeat (FD) step();

    // Program-load window: loader writes while the CPU is held off
    ld_hold = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'd5;
    ld_write(12'd2, 16'h2000);
    ld_write(12'd3, 16'h0008);
    ld_write(12'd7, 16'h7000);
    ld_req = 0; ld_we = 0; ld_hold = 0;
    cpu_addr = 12'd2;
    step();
    check_eq("cpu_rd_addr2", {16'b0, cpu_rdata}, 32'h2000);
    cpu_req = 0;
    step();

    // Contention: both reading for 6 cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'd3;
    ld_req = 1; ld_we = 0; ld_addr = 12'd7;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rr_order", {31'b0, cpu_rvalid}, {31'b0, ((i % 2) == 0) ? 1'b1 : 1'b0});
    end
    ld_req = 0;

    // Read granted just before the flush pulse still returns
    cpu_addr = 12'd7;
    step();
    flush_req = 1;
    step();
    flush_req = 0;
    for (int i = 0; i < FD; i++) begin
      flush_req = (i == 50);
      step();
    end
    flush_req = 0;
    step();
    check_eq("addr7_after_flush", {16'b0, cpu_rdata}, 32'h0);
    cpu_req = 0;
    step();

    // Reset in the middle of a flush
    flush_req = 1;
    step();
    flush_req = 0;
    repeat (100) step();
    rst = 0;
    #1 check_reset_outputs("mid_flush");
    @(negedge clk);
    rst = 1;
    model_reset();
    repeat (FD) step();

    // Reset with a read in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'd3;
    #1 check_eq("pre_rst_gnt", {31'b0, cpu_gnt}, 32'h1);
    #1 rst = 0;
    #1 check_reset_outputs("mid_access");
    @(posedge clk);
    #1 check_eq("dropped_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    @(negedge clk);
    cpu_req = 0;
    rst = 1;
    model_reset();
    repeat (FD) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 12'($urandom_range(0, 511));
      cpu_wdata = 16'($urandom);
      ld_req    = $urandom_range(0, 1);
      ld_we     = $urandom_range(0, 1);
      ld_addr   = 12'($urandom_range(0, 511));
      ld_wdata  = 16'($urandom);
      ld_hold   = ($urandom_range(0, 4) == 0);
      flush_req = ($urandom_range(0, 199) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
